// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle signed multiply/divide engine with pipeline stall sequencing
module muldiv_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               halt_sys,
  input  logic               abort,
  input  logic               start,
  input  logic               op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               stall_req,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               div0,
  output logic               overflow
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, nxt;
  logic op_r, sign_a, sign_b, neg, ovf_fix;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] abs_a, abs_b, mp, sh;
  logic [WIDTH+1:0] diff;
  logic [2*WIDTH-1:0] mc, acc, prod, res_fix;
  logic [WIDTH-1:0] quo, rem;
  assign abs_a = a[WIDTH-1] ? -{a[WIDTH-1], a} : {a[WIDTH-1], a};
  assign abs_b = b[WIDTH-1] ? -{b[WIDTH-1], b} : {b[WIDTH-1], b};
  assign sh = {acc[WIDTH-1:0], mc[WIDTH-1]};
  assign diff = {1'b0, sh} - {1'b0, mp};
  assign neg = sign_a ^ sign_b;
  assign prod = neg ? -acc : acc;
  assign quo = neg ? -mc[WIDTH-1:0] : mc[WIDTH-1:0];
  assign rem = sign_a ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign res_fix = op_r ? {rem, quo} : prod;
  assign ovf_fix = op_r ? (~neg & mc[WIDTH-1]) : (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});
  assign stall_req = (state == IDLE && start) || state == CALC || state == FIX;
  always_comb begin
    nxt = state;
    if (abort) nxt = IDLE;
    else case (state)
      IDLE:    if (start) nxt = (op && b == '0) ? DONE : CALC;
      CALC:    if (cnt == '0) nxt = FIX;
      FIX:     nxt = DONE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      div0     <= 1'b0;
      overflow <= 1'b0;
      op_r     <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      cnt      <= '0;
      mc       <= '0;
      mp       <= '0;
      acc      <= '0;
    end else if (!halt_sys) begin
      state <= nxt;
      busy  <= nxt == CALC || nxt == FIX;
      done  <= state == DONE && !abort;
      if (!abort) begin
        if (state == IDLE && start) begin
          op_r     <= op;
          sign_a   <= a[WIDTH-1];
          sign_b   <= b[WIDTH-1];
          mc       <= {{(WIDTH-1){1'b0}}, abs_a};
          mp       <= abs_b;
          acc      <= '0;
          cnt      <= CW'(WIDTH-1);
          div0     <= op && b == '0;
          overflow <= 1'b0;
          if (op && b == '0) result <= {a, {WIDTH{1'b1}}};
        end else if (state == CALC) begin
          cnt <= cnt - 1'b1;
          mc  <= {mc[2*WIDTH-2:0], op_r ? ~diff[WIDTH+1] : 1'b0};
          mp  <= op_r ? mp : mp >> 1;
          acc <= op_r ? {{(WIDTH-1){1'b0}}, diff[WIDTH+1] ? sh : diff[WIDTH:0]}
                      : acc + (mp[0] ? mc : '0);
        end else if (state == FIX) begin
          result   <= res_fix;
          overflow <= ovf_fix;
        end
      end
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: scoreboard bench, expected results queued at issue and checked on done
module tb_muldiv_sequencer;
  logic clk = 0, rst = 1, halt_sys = 0, abort = 0, start = 0, op = 0;
  logic [15:0] a = 0, b = 0;
  logic busy, stall_req, done, div0, overflow;
  logic [31:0] result;
  int cyc = 0, n_tests = 0, n_fail = 0, k = 0;
  typedef struct {
    logic [31:0] res;
    logic d0;
    logic ov;
    int at;
  } exp_t;
  exp_t sb[$];
  muldiv_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .halt_sys(halt_sys), .abort(abort), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .stall_req(stall_req), .done(done), .result(result),
    .div0(div0), .overflow(overflow)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) chk("spurious_done", 32'(done), 32'd0);
        else begin
          e = sb.pop_front();
          chk("result", result, e.res);
          chk("div0", 32'(div0), 32'(e.d0));
          chk("overflow", 32'(overflow), 32'(e.ov));
          chk("done_cycle", 32'(cyc), 32'(e.at));
        end
      end
    end
  endtask
  task automatic issue(input logic o, input logic [15:0] x, input logic [15:0] y, output int kk);
    @(negedge clk);
    start = 1; op = o; a = x; b = y;
    #1 chk("stall_at_start", 32'(stall_req), 32'd1);
    @(posedge clk);
    #1 kk = cyc;
    start = 0;
  endtask
  task automatic expect_res(input int kk, input int lat, input logic [31:0] r, input logic d0, input logic ov);
    sb.push_back('{r, d0, ov, kk + lat});
  endtask
  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask
  initial begin
    fork monitor(); join_none
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", result, 0);
    chk("rst_div0", 32'(div0), 0);
    chk("rst_ovf", 32'(overflow), 0);
    rst = 0;
    issue(0, 16'd7, 16'hFFFD, k);
    expect_res(k, 18, 32'hFFFF_FFEB, 0, 0);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      chk("stall_calc_fix", 32'(stall_req), 1);
    end
    @(negedge clk);
    chk("stall_done_low", 32'(stall_req), 0);
    drain();
    issue(1, 16'hFF9C, 16'd7, k);       expect_res(k, 18, 32'hFFFE_FFF2, 0, 0); drain();
    issue(0, 16'd300, 16'd300, k);      expect_res(k, 18, 32'h0001_5F90, 0, 1); drain();
    issue(1, 16'd5, 16'd0, k);          expect_res(k, 1, 32'h0005_FFFF, 1, 0);
    chk("div0_no_calc", 32'(busy), 0);  drain();
    issue(1, 16'h8000, 16'hFFFF, k);    expect_res(k, 18, 32'h0000_8000, 0, 1); drain();
    issue(0, 16'h8000, 16'h8000, k);    expect_res(k, 18, 32'h4000_0000, 0, 1); drain();
    issue(0, 16'h8000, 16'h0001, k);    expect_res(k, 18, 32'hFFFF_8000, 0, 0); drain();
    issue(1, 16'd7, 16'hFFFE, k);       expect_res(k, 18, 32'h0001_FFFD, 0, 0); drain();
    issue(1, 16'hFFF9, 16'd2, k);       expect_res(k, 18, 32'hFFFF_FFFD, 0, 0); drain();
    issue(0, 16'd7, 16'hFFFD, k);       expect_res(k, 23, 32'hFFFF_FFEB, 0, 0);
    repeat (4) @(negedge clk);
    halt_sys = 1;
    #1 chk("halt_stall", 32'(stall_req), 1);
    repeat (5) @(negedge clk);
    chk("halt_busy", 32'(busy), 1);
    halt_sys = 0;
    drain();
    issue(0, 16'd300, 16'd300, k);
    repeat (5) @(negedge clk);
    abort = 1;
    @(posedge clk);
    #1 abort = 0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_stall", 32'(stall_req), 0);
    repeat (25) @(negedge clk);
    chk("abort_result", result, 32'hFFFF_FFEB);
    chk("abort_ovf", 32'(overflow), 0);
    issue(0, 16'd300, 16'd300, k);      expect_res(k, 18, 32'h0001_5F90, 0, 1);
    repeat (3) @(negedge clk);
    start = 1; op = 1; a = 16'd5; b = 16'd0;
    @(negedge clk);
    start = 0;
    drain();
    issue(1, 16'hFF9C, 16'd7, k);
    repeat (5) @(negedge clk);
    rst = 1;
    #1 chk("arst_result", result, 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_ovf", 32'(overflow), 0);
    chk("arst_stall", 32'(stall_req), 0);
    @(negedge clk);
    rst = 0;
    issue(0, 16'd7, 16'hFFFD, k);       expect_res(k, 18, 32'hFFFF_FFEB, 0, 0); drain();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
